// File: rtl/rvh_ptw_req_ctrl.sv
// rvh_ptw_req_ctrl
//   Front end of the page-table walker. It arbitrates DTLB and ITLB miss
//   requests, keeps a single walk outstanding, forwards that walk to the
//   PTW and routes the walk result back to the TLB that asked for it.
//   flush_i cancels the outstanding walk. A response that is already in
//   flight is absorbed silently.
//
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   dtlb/itlb_miss_req_vld_i/vpn_i miss requests from the TLBs
//   dtlb/itlb_miss_req_rdy_o       request accepted (combinational in IDLE)
//   ptw_walk_req_vld/vpn/id_o      walk request to the PTW (id 1 = DTLB)
//   ptw_walk_req_rdy_i             PTW accepts the walk request
//   ptw_walk_resp_vld/pte/excp_i   walk result from the PTW
//   dtlb/itlb_miss_resp_vld_o      one-cycle refill strobe per TLB
//   miss_resp_pte_o/excp_o         shared refill payload (held between walks)
//   flush_i                        cancel the outstanding walk
module rvh_ptw_req_ctrl #(
    parameter int DTLB_PRIOR = 1,
    parameter int VPN_W      = 27,
    parameter int PTE_W      = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             dtlb_miss_req_vld_i,
    input  logic [VPN_W-1:0] dtlb_miss_req_vpn_i,
    output logic             dtlb_miss_req_rdy_o,
    input  logic             itlb_miss_req_vld_i,
    input  logic [VPN_W-1:0] itlb_miss_req_vpn_i,
    output logic             itlb_miss_req_rdy_o,
    output logic             ptw_walk_req_vld_o,
    output logic [VPN_W-1:0] ptw_walk_req_vpn_o,
    output logic             ptw_walk_req_id_o,
    input  logic             ptw_walk_req_rdy_i,
    input  logic             ptw_walk_resp_vld_i,
    input  logic [PTE_W-1:0] ptw_walk_resp_pte_i,
    input  logic             ptw_walk_resp_excp_i,
    output logic             dtlb_miss_resp_vld_o,
    output logic             itlb_miss_resp_vld_o,
    output logic [PTE_W-1:0] miss_resp_pte_o,
    output logic             miss_resp_excp_o,
    input  logic             flush_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [VPN_W-1:0]   vpn_q,   vpn_d;
    logic               id_q,    id_d;
    logic [PTE_W-1:0]   pte_q,   pte_d;
    logic               excp_q,  excp_d;
    logic               drop_q,  drop_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            vpn_q   <= '0;
            id_q    <= 1'b0;
            pte_q   <= '0;
            excp_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            id_q    <= id_d;
            pte_q   <= pte_d;
            excp_q  <= excp_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        vpn_d               = vpn_q;
        id_d                = id_q;
        pte_d               = pte_q;
        excp_d              = excp_q;
        drop_d              = drop_q;
        dtlb_miss_req_rdy_o = 1'b0;
        itlb_miss_req_rdy_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!flush_i) begin
                    if (DTLB_PRIOR != 0) begin
                        dtlb_miss_req_rdy_o = dtlb_miss_req_vld_i;
                        itlb_miss_req_rdy_o = itlb_miss_req_vld_i & ~dtlb_miss_req_vld_i;
                    end else begin
                        itlb_miss_req_rdy_o = itlb_miss_req_vld_i;
                        dtlb_miss_req_rdy_o = dtlb_miss_req_vld_i & ~itlb_miss_req_vld_i;
                    end
                end
                // rdy already implies the matching vld, so it alone is the grant.
                if (dtlb_miss_req_rdy_o) begin
                    vpn_d   = dtlb_miss_req_vpn_i;
                    id_d    = 1'b1;
                    state_d = S_REQ;
                end else if (itlb_miss_req_rdy_o) begin
                    vpn_d   = itlb_miss_req_vpn_i;
                    id_d    = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A handshake in the flush cycle means the PTW already owns
                // the walk: follow it to WAIT and discard its result.
                if (ptw_walk_req_rdy_i) begin
                    state_d = S_WAIT;
                    drop_d  = flush_i;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (ptw_walk_resp_vld_i) begin
                    if (drop_q || flush_i) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        pte_d   = ptw_walk_resp_pte_i;
                        excp_d  = ptw_walk_resp_excp_i;
                        state_d = S_RESP;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ptw_walk_req_vld_o   = (state_q == S_REQ);
    assign ptw_walk_req_vpn_o   = vpn_q;
    assign ptw_walk_req_id_o    = id_q;
    assign dtlb_miss_resp_vld_o = (state_q == S_RESP) & ~flush_i &  id_q;
    assign itlb_miss_resp_vld_o = (state_q == S_RESP) & ~flush_i & ~id_q;
    assign miss_resp_pte_o      = pte_q;
    assign miss_resp_excp_o     = excp_q;

endmodule

// File: tb/tb_rvh_ptw_req_ctrl.sv
module tb_rvh_ptw_req_ctrl;

    localparam int VPN_W = 27;
    localparam int PTE_W = 64;

    logic             clk;
    logic             rstn;
    logic             dvld, ivld, wrdy, rvld, rexcp, flush;
    logic [VPN_W-1:0] dvpn, ivpn;
    logic [PTE_W-1:0] rpte;
    logic             drdy, irdy, wvld, wid, dresp, iresp, mexcp;
    logic [VPN_W-1:0] wvpn;
    logic [PTE_W-1:0] mpte;

    // ITLB-priority instance, used for arbitration only
    logic             p0_dvld, p0_ivld;
    logic [VPN_W-1:0] p0_dvpn, p0_ivpn;
    logic             p0_drdy, p0_irdy, p0_wvld, p0_wid, p0_dresp, p0_iresp, p0_mexcp;
    logic [VPN_W-1:0] p0_wvpn;
    logic [PTE_W-1:0] p0_mpte;

    typedef struct packed {
        logic             id;
        logic [PTE_W-1:0] pte;
        logic             excp;
    } exp_t;

    exp_t             sbq[$];
    exp_t             e;
    logic [PTE_W-1:0] last_pte;
    int               n_chk;
    int               n_fail;

    rvh_ptw_req_ctrl #(.DTLB_PRIOR(1), .VPN_W(VPN_W), .PTE_W(PTE_W)) u_dut (
        .clk(clk), .rstn(rstn),
        .dtlb_miss_req_vld_i(dvld), .dtlb_miss_req_vpn_i(dvpn), .dtlb_miss_req_rdy_o(drdy),
        .itlb_miss_req_vld_i(ivld), .itlb_miss_req_vpn_i(ivpn), .itlb_miss_req_rdy_o(irdy),
        .ptw_walk_req_vld_o(wvld), .ptw_walk_req_vpn_o(wvpn), .ptw_walk_req_id_o(wid),
        .ptw_walk_req_rdy_i(wrdy),
        .ptw_walk_resp_vld_i(rvld), .ptw_walk_resp_pte_i(rpte), .ptw_walk_resp_excp_i(rexcp),
        .dtlb_miss_resp_vld_o(dresp), .itlb_miss_resp_vld_o(iresp),
        .miss_resp_pte_o(mpte), .miss_resp_excp_o(mexcp),
        .flush_i(flush)
    );

    rvh_ptw_req_ctrl #(.DTLB_PRIOR(0), .VPN_W(VPN_W), .PTE_W(PTE_W)) u_dut_p0 (
        .clk(clk), .rstn(rstn),
        .dtlb_miss_req_vld_i(p0_dvld), .dtlb_miss_req_vpn_i(p0_dvpn), .dtlb_miss_req_rdy_o(p0_drdy),
        .itlb_miss_req_vld_i(p0_ivld), .itlb_miss_req_vpn_i(p0_ivpn), .itlb_miss_req_rdy_o(p0_irdy),
        .ptw_walk_req_vld_o(p0_wvld), .ptw_walk_req_vpn_o(p0_wvpn), .ptw_walk_req_id_o(p0_wid),
        .ptw_walk_req_rdy_i(1'b0),
        .ptw_walk_resp_vld_i(1'b0), .ptw_walk_resp_pte_i('0), .ptw_walk_resp_excp_i(1'b0),
        .dtlb_miss_resp_vld_o(p0_dresp), .itlb_miss_resp_vld_o(p0_iresp),
        .miss_resp_pte_o(p0_mpte), .miss_resp_excp_o(p0_mexcp),
        .flush_i(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (wvld !== 1'b0)  begin n_fail++; $display("FAIL rst_wvld: got %b want 0", wvld); end
        n_chk++; if ({dresp, iresp} !== 2'b00) begin n_fail++; $display("FAIL rst_resp: got %b want 00", {dresp, iresp}); end
        n_chk++; if (mpte !== '0 || mexcp !== 1'b0) begin n_fail++; $display("FAIL rst_payload: got %h/%b want 0/0", mpte, mexcp); end
        n_chk++; if (wvpn !== '0 || wid !== 1'b0) begin n_fail++; $display("FAIL rst_vpn_id: got %h/%b want 0/0", wvpn, wid); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_arbitration();
        dvld = 1'b1; dvpn = 'h123; ivld = 1'b1; ivpn = 'h456;
        p0_dvld = 1'b1; p0_dvpn = 'h123; p0_ivld = 1'b1; p0_ivpn = 'h456;
        #1;
        n_chk++; if ({drdy, irdy} !== 2'b10) begin n_fail++; $display("FAIL arb_dprior_rdy: got %b want 10", {drdy, irdy}); end
        n_chk++; if ({p0_drdy, p0_irdy} !== 2'b01) begin n_fail++; $display("FAIL arb_iprior_rdy: got %b want 01", {p0_drdy, p0_irdy}); end
        step();
        dvld = 1'b0; ivld = 1'b0; p0_dvld = 1'b0; p0_ivld = 1'b0;
        #1;
        n_chk++; if ({wvld, wid} !== 2'b11 || wvpn !== 'h123) begin n_fail++; $display("FAIL arb_walk_req: got vld/id %b vpn %h want 11 123", {wvld, wid}, wvpn); end
        n_chk++; if ({p0_wvld, p0_wid} !== 2'b10 || p0_wvpn !== 'h456) begin n_fail++; $display("FAIL arb_iprior_walk: got vld/id %b vpn %h want 10 456", {p0_wvld, p0_wid}, p0_wvpn); end
    endtask

    // Continues the DTLB walk granted by test_arbitration (now in REQ).
    task automatic test_dtlb_walk();
        step();
        wrdy = 1'b1;
        step();
        wrdy = 1'b0;
        #1;
        n_chk++; if (wvld !== 1'b0) begin n_fail++; $display("FAIL walk_wait_vld: got %b want 0", wvld); end
        rvld = 1'b1; rpte = 'hABCD; rexcp = 1'b0;
        sbq.push_back('{id: 1'b1, pte: 'hABCD, excp: 1'b0});
        step();
        rvld = 1'b0;
        #1;
        n_chk++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL walk_sb_empty: got 0 entries want 1"); end
        else begin
            e = sbq.pop_front();
            if ({dresp, iresp} !== {e.id, ~e.id} || mpte !== e.pte || mexcp !== e.excp) begin
                n_fail++; $display("FAIL walk_resp: got d/i %b pte %h excp %b want %b %h %b", {dresp, iresp}, mpte, mexcp, {e.id, ~e.id}, e.pte, e.excp);
            end
            last_pte = e.pte;
        end
        step();
        #1;
        n_chk++; if ({dresp, iresp} !== 2'b00 || mpte !== last_pte) begin n_fail++; $display("FAIL walk_after_resp: got %b pte %h want 00 %h", {dresp, iresp}, mpte, last_pte); end
    endtask

    task automatic test_stall_itlb();
        step();
        ivld = 1'b1; ivpn = 'h2AA;
        #1;
        n_chk++; if ({drdy, irdy} !== 2'b01) begin n_fail++; $display("FAIL stall_grant: got %b want 01", {drdy, irdy}); end
        step();
        dvld = 1'b1; ivld = 1'b1; ivpn = 'h111;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++;
            if ({wvld, wid} !== 2'b10 || wvpn !== 'h2AA || {drdy, irdy} !== 2'b00) begin
                n_fail++; $display("FAIL stall_cyc%0d: got vld/id %b vpn %h rdy %b want 10 2aa 00", i, {wvld, wid}, wvpn, {drdy, irdy});
            end
            step();
        end
        dvld = 1'b0; ivld = 1'b0; wrdy = 1'b1;
        step();
        wrdy = 1'b0; rvld = 1'b1; rpte = 'h55; rexcp = 1'b1;
        sbq.push_back('{id: 1'b0, pte: 'h55, excp: 1'b1});
        step();
        rvld = 1'b0;
        #1;
        n_chk++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL stall_sb_empty: got 0 entries want 1"); end
        else begin
            e = sbq.pop_front();
            if ({dresp, iresp} !== {e.id, ~e.id} || mpte !== e.pte || mexcp !== e.excp) begin
                n_fail++; $display("FAIL stall_resp: got d/i %b pte %h excp %b want %b %h %b", {dresp, iresp}, mpte, mexcp, {e.id, ~e.id}, e.pte, e.excp);
            end
            last_pte = e.pte;
        end
        step();
    endtask

    task automatic test_flush_wait();
        ivld = 1'b1; ivpn = 'h333;
        step();
        ivld = 1'b0; wrdy = 1'b1;
        step();
        wrdy = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; dvld = 1'b1;
        #1;
        n_chk++; if ({drdy, wvld} !== 2'b00) begin n_fail++; $display("FAIL flushw_busy: got rdy/vld %b want 00", {drdy, wvld}); end
        dvld = 1'b0; rvld = 1'b1; rpte = 'h777;
        step();
        rvld = 1'b0; dvld = 1'b1; dvpn = 'h444;
        #1;
        n_chk++; if ({dresp, iresp} !== 2'b00 || mpte !== last_pte) begin n_fail++; $display("FAIL flushw_drop: got %b pte %h want 00 %h", {dresp, iresp}, mpte, last_pte); end
        n_chk++; if (drdy !== 1'b1) begin n_fail++; $display("FAIL flushw_idle_rdy: got %b want 1", drdy); end
        step();
        dvld = 1'b0;
        #1;
        n_chk++; if ({wvld, wid} !== 2'b11 || wvpn !== 'h444) begin n_fail++; $display("FAIL flushw_regrant: got %b vpn %h want 11 444", {wvld, wid}, wvpn); end
        wrdy = 1'b1;
        step();
        wrdy = 1'b0; rvld = 1'b1; rpte = 'h999; rexcp = 1'b0;
        sbq.push_back('{id: 1'b1, pte: 'h999, excp: 1'b0});
        step();
        rvld = 1'b0;
        #1;
        n_chk++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL flushw_sb_empty: got 0 entries want 1"); end
        else begin
            e = sbq.pop_front();
            if ({dresp, iresp} !== {e.id, ~e.id} || mpte !== e.pte) begin
                n_fail++; $display("FAIL flushw_resp: got d/i %b pte %h want %b %h", {dresp, iresp}, mpte, {e.id, ~e.id}, e.pte);
            end
            last_pte = e.pte;
        end
        step();
    endtask

    task automatic test_flush_corners();
        // flush in REQ without PTW acceptance
        dvld = 1'b1; dvpn = 'h10;
        step();
        dvld = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; dvld = 1'b1; dvpn = 'h20;
        #1;
        n_chk++; if ({wvld, drdy} !== 2'b01) begin n_fail++; $display("FAIL flushr_idle: got vld/rdy %b want 01", {wvld, drdy}); end
        // flush and PTW acceptance in the same REQ cycle
        step();
        dvld = 1'b0; flush = 1'b1; wrdy = 1'b1;
        step();
        flush = 1'b0; wrdy = 1'b0;
        #1;
        n_chk++; if (wvld !== 1'b0) begin n_fail++; $display("FAIL flushr_hs_wait: got %b want 0", wvld); end
        rvld = 1'b1; rpte = 'h888;
        step();
        rvld = 1'b0;
        #1;
        n_chk++; if ({dresp, iresp} !== 2'b00) begin n_fail++; $display("FAIL flushr_hs_drop: got %b want 00", {dresp, iresp}); end
        // flush and response in the same WAIT cycle
        ivld = 1'b1; ivpn = 'h30;
        step();
        ivld = 1'b0; wrdy = 1'b1;
        step();
        wrdy = 1'b0; flush = 1'b1; rvld = 1'b1; rpte = 'h999;
        step();
        flush = 1'b0; rvld = 1'b0; ivld = 1'b1;
        #1;
        n_chk++; if ({dresp, iresp, irdy} !== 3'b001) begin n_fail++; $display("FAIL flushw_same: got resp/rdy %b want 001", {dresp, iresp, irdy}); end
        // flush in RESP
        step();
        ivld = 1'b0; wrdy = 1'b1;
        step();
        wrdy = 1'b0; rvld = 1'b1; rpte = 'hAAA;
        step();
        rvld = 1'b0; flush = 1'b1;
        #1;
        n_chk++; if ({dresp, iresp} !== 2'b00) begin n_fail++; $display("FAIL flush_resp_supp: got %b want 00", {dresp, iresp}); end
        last_pte = 'hAAA;
        step();
        flush = 1'b0; dvld = 1'b1;
        #1;
        n_chk++; if ({dresp, iresp, drdy} !== 3'b001) begin n_fail++; $display("FAIL flush_resp_idle: got resp/rdy %b want 001", {dresp, iresp, drdy}); end
        dvld = 1'b0;
    endtask

    task automatic test_ignore_resp();
        rvld = 1'b1; rpte = 'hDEAD;
        step();
        rvld = 1'b0;
        #1;
        n_chk++; if ({dresp, iresp} !== 2'b00 || mpte !== last_pte) begin n_fail++; $display("FAIL ign_idle: got %b pte %h want 00 %h", {dresp, iresp}, mpte, last_pte); end
        ivld = 1'b1; ivpn = 'h5A5;
        step();
        ivld = 1'b0; rvld = 1'b1; rpte = 'hBAD;
        step();
        rvld = 1'b0;
        #1;
        n_chk++; if (wvld !== 1'b1 || {dresp, iresp} !== 2'b00) begin n_fail++; $display("FAIL ign_req: got vld %b resp %b want 1 00", wvld, {dresp, iresp}); end
        wrdy = 1'b1;
        step();
        wrdy = 1'b0; rvld = 1'b1; rpte = 'h5151; rexcp = 1'b0;
        sbq.push_back('{id: 1'b0, pte: 'h5151, excp: 1'b0});
        step();
        rvld = 1'b0;
        #1;
        n_chk++;
        if (sbq.size() == 0) begin n_fail++; $display("FAIL ign_sb_empty: got 0 entries want 1"); end
        else begin
            e = sbq.pop_front();
            if ({dresp, iresp} !== {e.id, ~e.id} || mpte !== e.pte) begin
                n_fail++; $display("FAIL ign_resp: got d/i %b pte %h want %b %h", {dresp, iresp}, mpte, {e.id, ~e.id}, e.pte);
            end
            last_pte = e.pte;
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            dvld = (k == 0); ivld = (k == 1);
            dvpn = 'h700 + k; ivpn = 'h700 + k;
            #1;
            n_chk++; if ({drdy, irdy} !== {k == 0, k == 1}) begin n_fail++; $display("FAIL b2b_rdy%0d: got %b want %b", k, {drdy, irdy}, {k == 0, k == 1}); end
            step();
            dvld = 1'b0; ivld = 1'b0; wrdy = 1'b1;
            step();
            wrdy = 1'b0; rvld = 1'b1; rpte = PTE_W'(64'h1000 + k); rexcp = k[0];
            sbq.push_back('{id: (k == 0), pte: PTE_W'(64'h1000 + k), excp: k[0]});
            step();
            rvld = 1'b0;
            #1;
            n_chk++;
            if (sbq.size() == 0) begin n_fail++; $display("FAIL b2b_sb_empty%0d: got 0 entries want 1", k); end
            else begin
                e = sbq.pop_front();
                if ({dresp, iresp} !== {e.id, ~e.id} || mpte !== e.pte || mexcp !== e.excp) begin
                    n_fail++; $display("FAIL b2b_resp%0d: got d/i %b pte %h excp %b want %b %h %b", k, {dresp, iresp}, mpte, mexcp, {e.id, ~e.id}, e.pte, e.excp);
                end
                last_pte = e.pte;
            end
            step();
        end
    endtask

    task automatic test_reset_midwalk();
        dvld = 1'b1; dvpn = 'h3C3;
        step();
        dvld = 1'b0; wrdy = 1'b1;
        step();
        wrdy = 1'b0; rstn = 1'b0;
        #1;
        n_chk++; if ({wvld, dresp, iresp} !== 3'b000 || mpte !== '0) begin n_fail++; $display("FAIL rstw_async: got vld %b pte %h want 000 0", {wvld, dresp, iresp}, mpte); end
        step();
        rstn = 1'b1;
        step();
        rvld = 1'b1; rpte = 'hBEEF;
        step();
        rvld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if ({wvld, dresp, iresp} !== 3'b000 || mpte !== '0) begin n_fail++; $display("FAIL rstw_no_resp%0d: got %b pte %h want 000 0", i, {wvld, dresp, iresp}, mpte); end
            step();
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; last_pte = '0;
        rstn = 1'b0; dvld = 1'b0; ivld = 1'b0; dvpn = '0; ivpn = '0;
        wrdy = 1'b0; rvld = 1'b0; rpte = '0; rexcp = 1'b0; flush = 1'b0;
        p0_dvld = 1'b0; p0_ivld = 1'b0; p0_dvpn = '0; p0_ivpn = '0;
        test_reset();
        test_arbitration();
        test_dtlb_walk();
        test_stall_itlb();
        test_flush_wait();
        test_flush_corners();
        test_ignore_resp();
        test_back_to_back();
        test_reset_midwalk();
        n_chk++; if (sbq.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sbq.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rvh_ptw_req_ctrl.md
RVH_PTW_REQ_CTRL -- requirements
Module: rvh_ptw_req_ctrl

Interface
REQ-001 Parameter DTLB_PRIOR, default 1, SHALL set fixed grant priority (1: DTLB wins, 0: ITLB wins).
REQ-002 Parameter VPN_W, default 27, SHALL set the virtual page number width.
REQ-003 Parameter PTE_W, default 64, SHALL set the PTE width.
REQ-004 Port clk, in, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rstn, in, 1, SHALL be the reset: asynchronous, active-low.
REQ-006 Ports dtlb_miss_req_vld_i / itlb_miss_req_vld_i, in, 1, SHALL be the miss requests.
REQ-007 Ports dtlb_miss_req_vpn_i / itlb_miss_req_vpn_i, in, VPN_W, SHALL be the miss VPNs.
REQ-008 Ports dtlb_miss_req_rdy_o / itlb_miss_req_rdy_o, out, 1, SHALL be the accept signals.
REQ-009 Port ptw_walk_req_vld_o, out, 1, SHALL be the walk request valid to the PTW.
REQ-010 Port ptw_walk_req_vpn_o, out, VPN_W, SHALL be the walk VPN.
REQ-011 Port ptw_walk_req_id_o, out, 1, SHALL be the requester id (1 = DTLB, 0 = ITLB).
REQ-012 Port ptw_walk_req_rdy_i, in, 1, SHALL be PTW acceptance.
REQ-013 Ports ptw_walk_resp_vld_i (1), ptw_walk_resp_pte_i (PTE_W), ptw_walk_resp_excp_i (1), in, SHALL be the walk result.
REQ-014 Ports dtlb_miss_resp_vld_o / itlb_miss_resp_vld_o, out, 1, SHALL be the per-TLB refill valids.
REQ-015 Ports miss_resp_pte_o (PTE_W), miss_resp_excp_o (1), out, SHALL be the shared refill payload.
REQ-016 Port flush_i, in, 1, SHALL cancel the outstanding walk.

Function
REQ-017 The block SHALL have one outstanding walk and a four-state FSM: IDLE, REQ, WAIT, RESP.
REQ-018 In IDLE with flush_i=0, the rdy outputs SHALL be combinational arbitration: for DTLB_PRIOR=1, dtlb_rdy=dtlb_vld and itlb_rdy=itlb_vld&~dtlb_vld; for DTLB_PRIOR=0 the roles SHALL be swapped.
REQ-019 Outside IDLE, or when flush_i=1, both rdy outputs SHALL be 0.
REQ-020 On a grant (vld&rdy), the block SHALL latch VPN and id and go to REQ the next cycle.
REQ-021 In REQ, ptw_walk_req_vld_o SHALL be 1 with the latched VPN/id held stable until ptw_walk_req_rdy_i=1, then go to WAIT.
REQ-022 In WAIT, on ptw_walk_resp_vld_i=1 the block SHALL register pte/excp and go to RESP.
REQ-023 In RESP, exactly one of the resp valids, selected by the latched id, SHALL be 1 for exactly one cycle with the registered payload; then go to IDLE.
REQ-024 Latency: resp valid SHALL rise exactly one cycle after the ptw_walk_resp_vld_i cycle, and a new grant SHALL be possible in the cycle after RESP.
REQ-025 flush_i in REQ SHALL return to IDLE next cycle with ptw_walk_req_vld_o=0 that cycle; a same-cycle ptw_walk_req_rdy_i SHALL take precedence (go to WAIT, drop set).
REQ-026 flush_i in WAIT SHALL set a drop flag; the later response, or a same-cycle response, SHALL be consumed without any resp valid, then return to IDLE.
REQ-027 flush_i in RESP SHALL suppress both resp valids that cycle; the FSM still returns to IDLE.
REQ-028 ptw_walk_resp_vld_i outside WAIT SHALL be ignored.
REQ-029 miss_resp_pte_o and miss_resp_excp_o SHALL hold their last value outside RESP.

Reset
REQ-030 While rstn=0: FSM=IDLE, drop flag=0, latched VPN/id/pte/excp=0, all vld outputs=0.
REQ-031 Reset asserted mid-walk SHALL abandon the walk with no response forwarded.

Verification
REQ-032 DTLB_PRIOR=1, both vld with dtlb vpn=0x123, itlb vpn=0x456 -> dtlb_rdy=1, itlb_rdy=0; walk req vpn=0x123, id=1.
REQ-033 Walk accepted, ptw resp pte=0xABCD, excp=0 -> dtlb_miss_resp_vld_o=1 for one cycle, pte=0xABCD, the next cycle after the PTW response.
REQ-034 ptw_walk_req_rdy_i held 0 for 5 cycles -> req_vld=1 with stable VPN; both rdy outputs=0.
REQ-035 ITLB walk in WAIT, flush_i pulse, then PTW response -> no itlb/dtlb resp valid; IDLE next cycle; a new grant is accepted.
REQ-036 rstn dropped in WAIT -> all valids=0 immediately; after release, a later PTW response produces no output.
REQ-037 DTLB_PRIOR=0, both vld -> itlb wins with id=0.
